// File: rtl/axi_read_responder.sv
// AXI4 read subordinate, one burst outstanding, serving beats from a 1-cycle-latency RAM.
// First rvalid 2 cycles after AR, then one beat per 2 cycles; R outputs hold while rready is low.
module axi_read_responder #(
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8,
  parameter int RAM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_ar_arvalid,
  output logic                  axi_ar_arready,
  input  logic [AXI_ID_W-1:0]   axi_ar_arid,
  input  logic [AXI_ADDR_W-1:0] axi_ar_araddr,
  input  logic [3:0]            axi_ar_arregion,
  input  logic [3:0]            axi_ar_arcache,
  input  logic [3:0]            axi_ar_arqos,
  input  logic [2:0]            axi_ar_arprot,
  input  logic [7:0]            axi_ar_arlen,
  input  logic [2:0]            axi_ar_arsize,
  input  logic [1:0]            axi_ar_arburst,
  output logic                  axi_r_rvalid,
  input  logic                  axi_r_rready,
  output logic [AXI_ID_W-1:0]   axi_r_rid,
  output logic [AXI_DATA_W-1:0] axi_r_rdata,
  output logic [1:0]            axi_r_rresp,
  output logic                  axi_r_rlast,
  output logic                  ram_rd_en,
  output logic [RAM_ADDR_W-1:0] ram_rd_addr,
  input  logic [AXI_DATA_W-1:0] ram_rd_data
);

  localparam int         LG    = $clog2(AXI_DATA_W / 8);
  localparam logic [2:0] LG_SZ = 3'(LG);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [AXI_ID_W-1:0]   r_id;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [8:0]            r_beat;
  logic                  r_slverr;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_len_ok;
  logic                  w_ar_slverr;
  logic [AXI_ADDR_W-1:0] w_ar_mask;
  logic [AXI_ADDR_W-1:0] w_step;
  logic [AXI_ADDR_W-1:0] w_wrap_mask;
  logic [AXI_ADDR_W-1:0] w_addr_next;
  logic [AXI_ADDR_W-1:0] w_word;
  logic                  w_oor;
  logic                  w_err_beat;
  logic                  w_last;
  logic                  w_unused;

  assign w_unused = &{1'b0, axi_ar_arregion, axi_ar_arcache, axi_ar_arqos, axi_ar_arprot};

  assign w_ar_hs = axi_ar_arvalid & axi_ar_arready;
  assign w_r_hs  = axi_r_rvalid & axi_r_rready;

  // Protocol violations are decided once per burst and poison every beat.
  assign w_ar_mask   = (AXI_ADDR_W'(1) << axi_ar_arsize) - AXI_ADDR_W'(1);
  assign w_len_ok    = (axi_ar_arlen == 8'd1) || (axi_ar_arlen == 8'd3) ||
                       (axi_ar_arlen == 8'd7) || (axi_ar_arlen == 8'd15);
  assign w_ar_slverr = (axi_ar_arburst == 2'd3) || (axi_ar_arsize > LG_SZ) ||
                       ((axi_ar_arburst == 2'd2) && (!w_len_ok || (|(axi_ar_araddr & w_ar_mask))));

  assign w_step      = AXI_ADDR_W'(1) << r_size;
  assign w_wrap_mask = (AXI_ADDR_W'({1'b0, r_len} + 9'd1) << r_size) - AXI_ADDR_W'(1);

  always_comb begin
    w_addr_next = r_addr;
    case (r_burst)
      2'd1:    w_addr_next = r_addr + w_step;
      2'd2:    w_addr_next = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
      default: w_addr_next = r_addr;
    endcase
  end

  assign w_word      = r_addr >> LG;
  assign w_oor       = |(w_word >> RAM_ADDR_W);
  assign w_err_beat  = r_slverr | w_oor;
  assign w_last      = (r_beat == {1'b0, r_len});
  assign ram_rd_addr = RAM_ADDR_W'(w_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    axi_ar_arready = 1'b0;
    axi_r_rvalid   = 1'b0;
    axi_r_rid      = '0;
    axi_r_rdata    = '0;
    axi_r_rresp    = 2'd0;
    axi_r_rlast    = 1'b0;
    ram_rd_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        axi_ar_arready = rst;
        if (axi_ar_arvalid && rst) w_next = S_FETCH;
      end
      S_FETCH: begin
        ram_rd_en = !w_err_beat;
        w_next    = S_SEND;
      end
      S_SEND: begin
        axi_r_rvalid = 1'b1;
        axi_r_rid    = r_id;
        axi_r_rdata  = w_err_beat ? '0 : ram_rd_data;
        axi_r_rresp  = r_slverr ? 2'd2 : (w_oor ? 2'd3 : 2'd0);
        axi_r_rlast  = w_last;
        if (axi_r_rready) w_next = w_last ? S_IDLE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_beat   <= '0;
      r_slverr <= 1'b0;
    end else if (w_ar_hs) begin
      r_id     <= axi_ar_arid;
      r_addr   <= axi_ar_araddr;
      r_len    <= axi_ar_arlen;
      r_size   <= axi_ar_arsize;
      r_burst  <= axi_ar_arburst;
      r_beat   <= '0;
      r_slverr <= w_ar_slverr;
    end else if (w_r_hs && !w_last) begin
      r_addr   <= w_addr_next;
      r_beat   <= r_beat + 9'd1;
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Randomized and directed bench for axi_read_responder against a burst-level reference model.
// Includes a 1-cycle-latency RAM model and a monitor of RAM read strobes.
module tb_axi_read_responder;

  logic         clk;
  logic         rst;
  logic         arvalid;
  logic         arready;
  logic [7:0]   arid;
  logic [15:0]  araddr;
  logic [3:0]   arregion, arcache, arqos;
  logic [2:0]   arprot;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [7:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         ram_rd_en;
  logic [7:0]   ram_rd_addr;
  logic [127:0] ram_rd_data = '1;

  logic [127:0] mem [256];
  logic [7:0]   mq [$];
  int           n_chk = 0;
  int           n_pass = 0;

  axi_read_responder dut (
    .clk(clk), .rst(rst),
    .axi_ar_arvalid(arvalid), .axi_ar_arready(arready), .axi_ar_arid(arid),
    .axi_ar_araddr(araddr), .axi_ar_arregion(arregion), .axi_ar_arcache(arcache),
    .axi_ar_arqos(arqos), .axi_ar_arprot(arprot), .axi_ar_arlen(arlen),
    .axi_ar_arsize(arsize), .axi_ar_arburst(arburst),
    .axi_r_rvalid(rvalid), .axi_r_rready(rready), .axi_r_rid(rid),
    .axi_r_rdata(rdata), .axi_r_rresp(rresp), .axi_r_rlast(rlast),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  always @(negedge clk) if (ram_rd_en) mq.push_back(ram_rd_addr);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_len, input bit rnd);
    logic [127:0] e_data [$];
    logic [1:0]   e_resp [$];
    logic [7:0]   e_strb [$];
    logic [127:0] snap_d;
    logic [10:0]  snap_m;
    bit slv;
    int a, step, total, base, word, n, s, q0;
    slv = (burst == 3) || (size > 4) ||
          ((burst == 2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
          ((burst == 2) && ((int'(addr) % (1 << size)) != 0));
    a = int'(addr);
    step = 1 << size;
    total = (int'(len) + 1) * step;
    for (int i = 0; i <= int'(len); i++) begin
      word = a / 16;
      if (slv) begin
        e_resp.push_back(2'd2); e_data.push_back('0);
      end else if (word >= 256) begin
        e_resp.push_back(2'd3); e_data.push_back('0);
      end else begin
        e_resp.push_back(2'd0); e_data.push_back(mem[word]); e_strb.push_back(8'(word));
      end
      if (burst == 1) a = (a + step) % 65536;
      else if (burst == 2) begin
        base = a - (a % total);
        a = base + ((a - base + step) % total);
      end
    end

    mq.delete();
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arregion = 4'($urandom); arcache = 4'($urandom); arqos = 4'($urandom); arprot = 3'($urandom);
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    check("ar_accept", arready, 1);
    if (!arready) begin arvalid = 1'b0; return; end
    @(posedge clk); #1;
    if (rnd && $urandom_range(0, 1) == 1) arid = ~id;
    else arvalid = 1'b0;

    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (!rvalid) begin check("rvalid_timeout", 0, 1); arvalid = 1'b0; return; end
      if (i == 0) check("first_lat", n + 1, 2);
      else        check("beat_gap_ge2", (n + 1 >= 2), 1);
      check("ar_busy", arready, 0);
      s = rnd ? int'($urandom_range(0, 2)) : ((i == stall_beat) ? stall_len : 0);
      snap_d = rdata; snap_m = {rid, rlast, rresp}; q0 = mq.size();
      repeat (s) begin
        @(posedge clk); #1;
        check("hold_data", rdata, snap_d);
        check("hold_meta", {rid, rlast, rresp, rvalid}, {snap_m, 1'b1});
      end
      if (s > 0) check("stall_no_strobe", mq.size(), q0);
      check("rdata", rdata, e_data[i]);
      check("rid", rid, id);
      check("rresp", rresp, e_resp[i]);
      check("rlast", rlast, (i == int'(len)));
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
    arvalid = 1'b0;
    check("idle_rvalid", rvalid, 0);
    check("idle_arready", arready, 1);
    check("strobe_count", mq.size(), e_strb.size());
    if (mq.size() == e_strb.size())
      foreach (e_strb[k]) check("strobe_addr", mq[k], e_strb[k]);
  endtask

  task automatic reset_mid_burst();
    int seen;
    mq.delete();
    arid = 8'h33; araddr = 16'h0040; arlen = 8'd3; arsize = 3'd4; arburst = 2'd1; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && seen < 2; c++) begin
      if (rvalid) begin
        seen++;
        if (seen == 1) rready = 1'b1;
      end
      if (seen < 2) begin @(posedge clk); #1; rready = 1'b0; end
    end
    check("rst_beat2_reached", seen, 2);
    rst = 1'b0;
    #1;
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ram_en", ram_rd_en, 0);
    check("rst_ram_addr", ram_rd_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_release_arready", arready, 1);
    seen = 0;
    mq.delete();
    repeat (10) begin
      if (rvalid) seen++;
      @(posedge clk); #1;
    end
    check("no_stale_beats", seen, 0);
    check("no_stale_strobes", mq.size(), 0);
  endtask

  initial begin
    logic [1:0]  b;
    logic [2:0]  sz;
    logic [7:0]  ln;
    logic [15:0] ad;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b0; arvalid = 1'b0; rready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arregion = '0; arcache = '0; arqos = '0; arprot = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_arready", arready, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    check("reset_ram_en", ram_rd_en, 0);
    check("reset_ram_addr", ram_rd_addr, 0);
    check("reset_meta", {rid, rlast, rresp}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("arready_after_reset", arready, 1);

    run_burst(8'h5A, 16'h0010, 8'd3, 3'd4, 2'd1, -1, 0, 1'b0);
    run_burst(8'h11, 16'h0030, 8'd3, 3'd4, 2'd2, -1, 0, 1'b0);
    run_burst(8'h22, 16'h0050, 8'd3, 3'd4, 2'd1, 1, 5, 1'b0);
    run_burst(8'h44, 16'h0000, 8'd1, 3'd4, 2'd3, -1, 0, 1'b0);
    run_burst(8'h55, 16'h1000, 8'd0, 3'd4, 2'd1, -1, 0, 1'b0);
    run_burst(8'h66, 16'hFFF0, 8'd1, 3'd4, 2'd1, -1, 0, 1'b0);
    run_burst(8'h77, 16'h0008, 8'd2, 3'd3, 2'd2, -1, 0, 1'b0);
    run_burst(8'h88, 16'h0000, 8'd0, 3'd5, 2'd1, -1, 0, 1'b0);
    reset_mid_burst();
    run_burst(8'h99, 16'h0020, 8'd255, 3'd4, 2'd0, -1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      b  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sz = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'($urandom_range(0, 4));
      if (b == 2'd2 && $urandom_range(0, 7) != 0) ln = 8'((1 << $urandom_range(1, 4)) - 1);
      else ln = 8'($urandom_range(0, 15));
      ad = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 4095));
      if (b == 2'd2 && $urandom_range(0, 3) != 0) ad = ad & ~16'((1 << sz) - 1);
      run_burst(8'($urandom), ad, ln, sz, b, -1, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameters SHALL be:
- AXI_DATA_W, 128, R data width in bits; power of two, >= 8.
- AXI_ADDR_W, 16, AR byte-address width.
- AXI_ID_W, 8, AR/R ID width.
- RAM_ADDR_W, 8, RAM word-address width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, reset, asynchronous and active-low.
- axi_ar_arvalid, in, 1, AR valid.
- axi_ar_arready, out, 1, AR ready.
- axi_ar_arid, in, AXI_ID_W, AR ID.
- axi_ar_araddr, in, AXI_ADDR_W, AR byte address.
- axi_ar_arregion / axi_ar_arcache / axi_ar_arqos, in, 4 each, accepted and ignored.
- axi_ar_arprot, in, 3, accepted and ignored.
- axi_ar_arlen, in, 8, beats minus 1.
- axi_ar_arsize, in, 3, log2 of bytes per beat.
- axi_ar_arburst, in, 2, 0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved.
- axi_r_rvalid, out, 1, R valid.
- axi_r_rready, in, 1, R ready.
- axi_r_rid, out, AXI_ID_W, R ID.
- axi_r_rdata, out, AXI_DATA_W, R data.
- axi_r_rresp, out, 2, R response.
- axi_r_rlast, out, 1, last beat of the burst.
- ram_rd_en, out, 1, RAM read strobe.
- ram_rd_addr, out, RAM_ADDR_W, RAM word address.
- ram_rd_data, in, AXI_DATA_W, RAM read data; valid in the cycle after ram_rd_en and held until the next strobe.

Function
REQ-003 The block SHALL be an AXI4 read subordinate with one burst outstanding, implemented as FSM states IDLE, FETCH and SEND.
REQ-004 axi_ar_arready SHALL be 1 only in IDLE while rst is deasserted.
REQ-005 An AR handshake SHALL latch ID, address, len, size and burst, clear the beat counter, and move the FSM to FETCH.
REQ-006 In FETCH, the block SHALL assert ram_rd_en for exactly one cycle unless the beat is an error beat, and SHALL then move to SEND.
REQ-007 ram_rd_addr SHALL equal the current byte address shifted right by log2(AXI_DATA_W/8), truncated to RAM_ADDR_W.
REQ-008 In SEND, the outputs SHALL be:
- axi_r_rvalid = 1.
- axi_r_rdata = ram_rd_data, or 0 on an error beat.
- axi_r_rid = latched ID.
- axi_r_rlast = 1 iff beat count == arlen.
REQ-009 All R outputs SHALL stay stable while axi_r_rvalid=1 and axi_r_rready=0.
REQ-010 On an R handshake, the block SHALL move to IDLE if rlast=1; otherwise it SHALL advance the address, increment the beat count, and move to FETCH.
REQ-011 The first rvalid SHALL occur 2 cycles after the AR handshake cycle, and subsequent beats SHALL follow at best every 2 cycles.
REQ-012 Address advance SHALL follow the latched burst type:
- FIXED: address unchanged.
- INCR: address += 2^arsize, modulo 2^AXI_ADDR_W.
- WRAP: address += 2^arsize within the aligned window of (arlen+1)*2^arsize bytes, wrapping to the window base.
REQ-013 A burst SHALL be SLVERR (rresp=2) on every beat if any of the following holds:
- arburst=3.
- arsize > log2(AXI_DATA_W/8).
- WRAP with arlen not in {1, 3, 7, 15}.
- WRAP with araddr not aligned to 2^arsize.
REQ-014 A beat that is not SLVERR SHALL be DECERR (rresp=3) when its word address is >= 2^RAM_ADDR_W.
REQ-015 All other beats SHALL return rresp=0 (OKAY).
REQ-016 Error bursts SHALL still return exactly arlen+1 beats with rdata=0 and no ram_rd_en strobe.
REQ-017 Narrow transfers SHALL return the full RAM word unshifted.
REQ-018 arvalid asserted outside IDLE SHALL be ignored until the FSM is back in IDLE.
REQ-019 A 256-beat burst (arlen=255) SHALL complete with rlast on beat 256, using a 9-bit beat counter with no overflow.

Reset
REQ-020 While rst=0, the FSM SHALL be IDLE and all outputs SHALL be 0, including axi_ar_arready, axi_r_rvalid, axi_r_rlast, axi_r_rresp, axi_r_rid, axi_r_rdata, ram_rd_en and ram_rd_addr.
REQ-021 axi_ar_arready SHALL rise in the first cycle after rst deasserts.
REQ-022 Asserting rst mid-burst SHALL abandon the burst immediately, and after reset no further beats of that burst SHALL be sent.

Verification
REQ-023 INCR: araddr=0x0010, arlen=3, arsize=4, arid=0x5A, rready=1 -> ram_rd_addr 1,2,3,4; 4 beats with rid=0x5A and rresp=0; rlast on beat 4; first rvalid at AR+2.
REQ-024 WRAP: araddr=0x0030, arlen=3, arsize=4 -> ram_rd_addr 3,0,1,2.
REQ-025 Backpressure: rready=0 for 5 cycles on beat 2 -> rdata, rid and rlast held stable; no ram_rd_en during the stall.
REQ-026 Errors:
- arburst=3, arlen=1 -> 2 beats, rresp=2, rdata=0, no ram_rd_en.
- araddr=0x1000 with RAM_ADDR_W=8 -> rresp=3.
REQ-027 Reset mid-burst on beat 2 of 4 -> outputs 0 immediately; arready=1 one cycle after release; no stale beats.
REQ-028 FIXED: arlen=255, araddr=0x0020 -> 256 beats, all at ram_rd_addr 2, rlast only on beat 256.
